// File: rtl/alu_pkg.sv
// Shared types for the execute unit: opcode map, MDU FSM states and op classifiers.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_XOR    = 5'h02,
        OP_OR     = 5'h03,
        OP_AND    = 5'h04,
        OP_SLL    = 5'h05,
        OP_SRL    = 5'h06,
        OP_SRA    = 5'h07,
        OP_SLT    = 5'h08,
        OP_SLTU   = 5'h09,
        OP_JALR   = 5'h0A,
        OP_THRU   = 5'h0F,
        OP_MUL    = 5'h10,
        OP_MULH   = 5'h11,
        OP_MULHSU = 5'h12,
        OP_MULHU  = 5'h13,
        OP_DIV    = 5'h14,
        OP_DIVU   = 5'h15,
        OP_REM    = 5'h16,
        OP_REMU   = 5'h17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    // True for the eight multiply/divide codes 0x10-0x17.
    function automatic logic is_mdu_op(logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    // True for high-half multiplies whose first operand is signed.
    function automatic logic is_signed_hi(logic [4:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the pipeline and the execute unit.
// Handshake: a request transfers on a rising edge where in_valid & in_ready;
// a response transfers where out_valid & out_ready. A producer holding valid
// keeps its payload stable until the transfer; flush cancels any request.
interface alu_mdu_if #(parameter int XLEN = alu_pkg::XLEN_DEF);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/alu_core.sv
// Single-cycle base ALU: arithmetic, logic, shifts, compares, JALR target, pass-through.
module alu_core import alu_pkg::*; #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sum;

    assign shamt = src2[SHW-1:0];
    assign sum   = src1 + src2;

    // Opcode decode; unassigned codes 0xB-0xE yield zero.
    always_comb begin
        result = '0;
        case (alu_op_e'({1'b0, op}))
            OP_ADD:  result = sum;
            OP_SUB:  result = src1 - src2;
            OP_XOR:  result = src1 ^ src2;
            OP_OR:   result = src1 | src2;
            OP_AND:  result = src1 & src2;
            OP_SLL:  result = src1 << shamt;
            OP_SRL:  result = src1 >> shamt;
            OP_SRA:  result = $signed(src1) >>> shamt;
            OP_SLT:  result = XLEN'($signed(src1) < $signed(src2));
            OP_SLTU: result = XLEN'(src1 < src2);
            OP_JALR: result = {sum[XLEN-1:1], 1'b0};
            OP_THRU: result = src2;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu_mdu.sv
// Execute unit: one-cycle base ALU plus iterative shift-add multiply and
// restoring divide sharing one 2*XLEN accumulator (hi:lo / remainder:quotient).
module alu_mdu import alu_pkg::*; #(
    parameter int XLEN     = XLEN_DEF,
    parameter int ENABLE_M = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_mdu_if.slave   bus,
    output mdu_state_e state_dbg
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic MDU_EN = (ENABLE_M != 0);

    mdu_state_e        state, state_d;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb, result_q;
    logic [SHW-1:0]    cnt;
    logic              neg_q, rem_neg_q, is_div_q, out_valid_q;
    logic [1:0]        sel_q;

    logic              accept, retire, m_op, is_div, div_zero, div_ovf, fast_div;
    logic              go_mul, go_div, s1_neg, s2_neg;
    logic [XLEN-1:0]   core_res, fast_res, mag1, mag2, mul_add, done_res;
    logic [XLEN:0]     mul_sum, div_r, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;

    alu_core #(.XLEN(XLEN)) u_core (
        .src1   (bus.src1),
        .src2   (bus.src2),
        .op     (bus.op[3:0]),
        .result (core_res)
    );

    assign accept = bus.in_valid & bus.in_ready;
    assign retire = out_valid_q & bus.out_ready;

    // Request decode: operand magnitudes, sign flags, divide fast paths, one-cycle result.
    always_comb begin
        m_op     = MDU_EN && is_mdu_op(bus.op);
        is_div   = bus.op[2];
        div_zero = (bus.src2 == '0);
        div_ovf  = !bus.op[0] && (bus.src1 == SMIN) && (bus.src2 == '1);
        fast_div = m_op && is_div && (div_zero || div_ovf);
        go_mul   = accept && m_op && !is_div;
        go_div   = accept && m_op && is_div && !fast_div;
        s1_neg   = (is_signed_hi(bus.op) || (is_div && !bus.op[0])) && bus.src1[XLEN-1];
        s2_neg   = ((bus.op == OP_MULH) || (is_div && !bus.op[0])) && bus.src2[XLEN-1];
        mag1     = s1_neg ? -bus.src1 : bus.src1;
        mag2     = s2_neg ? -bus.src2 : bus.src2;
        fast_res = '0;
        if (!bus.op[4])  fast_res = core_res;
        else if (!m_op)  fast_res = '0;
        else if (div_zero) fast_res = bus.op[1] ? bus.src1 : '1;
        else if (div_ovf)  fast_res = bus.op[1] ? '0 : bus.src1;
    end

    // One iteration step of each algorithm plus final sign correction and selection.
    always_comb begin
        mul_add  = acc[0] ? opb : '0;
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_add};
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_r    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_r - {1'b0, opb};
        div_next = div_diff[XLEN] ? {div_r[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod     = neg_q ? -acc : acc;
        done_res = '0;
        if (!is_div_q)     done_res = (sel_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (sel_q[1]) done_res = rem_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        else               done_res = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:     if (go_mul) state_d = MUL; else if (go_div) state_d = DIV;
                MUL, DIV: if (cnt == '0) state_d = DONE;
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Handshake and status outputs.
    always_comb begin
        bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
        bus.busy      = (state == MUL) || (state == DIV);
        bus.out_valid = out_valid_q;
        bus.result    = result_q;
        state_dbg     = state;
    end

    // Datapath registers: operand capture, iteration, result load and out_valid tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; opb <= '0; cnt <= '0; result_q <= '0; out_valid_q <= 1'b0;
            neg_q <= 1'b0; rem_neg_q <= 1'b0; is_div_q <= 1'b0; sel_q <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else begin
            if (retire) out_valid_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (go_mul || go_div) begin
                        acc       <= {{XLEN{1'b0}}, mag1};
                        opb       <= mag2;
                        cnt       <= SHW'(XLEN - 1);
                        neg_q     <= s1_neg ^ s2_neg;
                        rem_neg_q <= s1_neg;
                        is_div_q  <= go_div;
                        sel_q     <= bus.op[1:0];
                    end else begin
                        result_q    <= fast_res;
                        out_valid_q <= 1'b1;
                    end
                end
                MUL: begin acc <= mul_next; cnt <= cnt - 1'b1; end
                DIV: begin acc <= div_next; cnt <= cnt - 1'b1; end
                DONE: begin result_q <= done_res; out_valid_q <= 1'b1; end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: 32-bit build with M extension and 64-bit build without.
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk, rst_n;
    mdu_state_e st32, st64;
    int checks = 0, errors = 0;

    alu_mdu_if #(.XLEN(32)) b32 ();
    alu_mdu_if #(.XLEN(64)) b64 ();

    alu_mdu #(.XLEN(32), .ENABLE_M(1)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave), .state_dbg(st32));
    alu_mdu #(.XLEN(64), .ENABLE_M(0)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave), .state_dbg(st64));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offer one op to the 32-bit unit; report result, edges after the
    // accepting edge until out_valid, and samples with busy high.
    task automatic run32(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bcnt);
        int guard = 0;
        @(negedge clk);
        b32.in_valid = 1'b1; b32.op = o; b32.src1 = a; b32.src2 = b;
        while (!b32.in_ready && guard < 50) begin @(negedge clk); guard++; end
        check("accept32", 64'(guard < 50), 64'd1);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        lat = 0; bcnt = 0;
        while (!b32.out_valid && lat < 100) begin
            if (b32.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check("outv32", 64'(b32.out_valid), 64'd1);
        res = b32.result;
    endtask

    task automatic run64(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
        int guard = 0;
        @(negedge clk);
        b64.in_valid = 1'b1; b64.op = o; b64.src1 = a; b64.src2 = b;
        while (!b64.in_ready && guard < 50) begin @(negedge clk); guard++; end
        check("accept64", 64'(guard < 50), 64'd1);
        @(posedge clk); #1;
        b64.in_valid = 1'b0;
        lat = 0;
        while (!b64.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = b64.result;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       tag;
    } vec_t;

    initial begin
        logic [31:0] r32;
        logic [63:0] r64;
        int lat, bcnt, seen;
        vec_t vecs[$];

        rst_n = 1'b0;
        b32.in_valid = 0; b32.op = '0; b32.src1 = '0; b32.src2 = '0; b32.flush = 0; b32.out_ready = 1;
        b64.in_valid = 0; b64.op = '0; b64.src1 = '0; b64.src2 = '0; b64.flush = 0; b64.out_ready = 1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outv", 64'(b32.out_valid), 64'd0);
        check("rst_result", 64'(b32.result), 64'd0);
        check("rst_busy", 64'(b32.busy), 64'd0);
        check("rst_state", 64'(st32), 64'(IDLE));
        check("rst_result64", b64.result, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(b32.in_ready), 64'd1);

        // directed vectors: lat 0 = valid right after accepting edge
        vecs.push_back('{5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, "add_ovf"});
        vecs.push_back('{5'h07, 32'h80000000, 32'd31,       32'hFFFFFFFF, 0, "sra31"});
        vecs.push_back('{5'h01, 32'd3,        32'd5,        32'hFFFFFFFE, 0, "sub"});
        vecs.push_back('{5'h02, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 0, "xor"});
        vecs.push_back('{5'h05, 32'h00000001, 32'd33,       32'h00000002, 0, "sll_mask"});
        vecs.push_back('{5'h08, 32'hFFFFFFFF, 32'd1,        32'h00000001, 0, "slt"});
        vecs.push_back('{5'h09, 32'hFFFFFFFF, 32'd1,        32'h00000000, 0, "sltu"});
        vecs.push_back('{5'h0A, 32'h00001001, 32'h00000002, 32'h00001002, 0, "jalr"});
        vecs.push_back('{5'h0F, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 0, "thru"});
        vecs.push_back('{5'h0C, 32'h12345678, 32'h1,        32'h00000000, 0, "illegal_c"});
        vecs.push_back('{5'h1B, 32'h12345678, 32'h1,        32'h00000000, 0, "illegal_1b"});
        vecs.push_back('{5'h11, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh"});
        vecs.push_back('{5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu"});
        vecs.push_back('{5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu"});
        vecs.push_back('{5'h10, 32'd3,        32'hFFFFFFFB, 32'hFFFFFFF1, 33, "mul"});
        vecs.push_back('{5'h14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div"});
        vecs.push_back('{5'h16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem"});
        vecs.push_back('{5'h15, 32'd100,      32'd7,        32'h0000000E, 33, "divu"});
        vecs.push_back('{5'h17, 32'd100,      32'd7,        32'h00000002, 33, "remu"});
        vecs.push_back('{5'h15, 32'd7,        32'd0,        32'hFFFFFFFF, 0, "divu_by0"});
        vecs.push_back('{5'h17, 32'd7,        32'd0,        32'h00000007, 0, "remu_by0"});
        vecs.push_back('{5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf"});
        vecs.push_back('{5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, "rem_ovf"});

        foreach (vecs[i]) begin
            run32(vecs[i].op, vecs[i].a, vecs[i].b, r32, lat, bcnt);
            check(vecs[i].tag, 64'(r32), 64'(vecs[i].exp));
            check({vecs[i].tag, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            if (vecs[i].tag == "mulh") check("mulh_busy", 64'(bcnt), 64'd32);
        end

        // back-pressure: result held, no accept; release with new op accepted same edge
        repeat (2) @(negedge clk);
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.op = 5'h00; b32.src1 = 32'd1; b32.src2 = 32'd2;
        @(posedge clk); #1;
        b32.src1 = 32'd10; b32.src2 = 32'd20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_result", 64'(b32.result), 64'd3);
            check("stall_in_ready", 64'(b32.in_ready), 64'd0);
        end
        @(negedge clk);
        b32.out_ready = 1'b1;
        #1 check("release_in_ready", 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check("nobubble_valid", 64'(b32.out_valid), 64'd1);
        check("nobubble_result", 64'(b32.result), 64'd30);

        // flush during DIVU iteration 10
        @(negedge clk);
        b32.in_valid = 1'b1; b32.op = 5'h15; b32.src1 = 32'hFFFFFFFF; b32.src2 = 32'd3;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_busy_before", 64'(b32.busy), 64'd1);
        b32.flush = 1'b1;
        #1 check("flush_in_ready", 64'(b32.in_ready), 64'd0);
        @(posedge clk); #1;
        b32.flush = 1'b0;
        #1;
        check("flush_outv", 64'(b32.out_valid), 64'd0);
        check("flush_busy", 64'(b32.busy), 64'd0);
        check("flush_ready", 64'(b32.in_ready), 64'd1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (b32.out_valid) seen++; end
        check("flush_no_emit", 64'(seen), 64'd0);
        run32(5'h01, 32'd5, 32'd9, r32, lat, bcnt);
        check("sub_after_flush", 64'(r32), 64'hFFFFFFFC);

        // async reset in the middle of a multiply
        @(negedge clk);
        b32.in_valid = 1'b1; b32.op = 5'h10; b32.src1 = 32'd7; b32.src2 = 32'd9;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(b32.busy), 64'd0);
        check("arst_outv", 64'(b32.out_valid), 64'd0);
        check("arst_result", 64'(b32.result), 64'd0);
        check("arst_state", 64'(st32), 64'(IDLE));
        @(negedge clk) rst_n = 1'b1;
        run32(5'h10, 32'd7, 32'd9, r32, lat, bcnt);
        check("mul_after_rst", 64'(r32), 64'd63);

        // 64-bit build without M extension
        run64(5'h00, 64'hFFFFFFFF_FFFFFFFF, 64'd1, r64, lat);
        check("add64", r64, 64'd0);
        run64(5'h07, 64'h80000000_00000000, 64'd63, r64, lat);
        check("sra64", r64, 64'hFFFFFFFF_FFFFFFFF);
        run64(5'h06, 64'h80000000_00000000, 64'd68, r64, lat);
        check("srl64_mask", r64, 64'h08000000_00000000);
        run64(5'h10, 64'd5, 64'd6, r64, lat);
        check("mul64_illegal", r64, 64'd0);
        check("mul64_lat", 64'(lat), 64'd0);
        run64(5'h17, 64'd100, 64'd7, r64, lat);
        check("remu64_illegal", r64, 64'd0);
        check("st64_idle", 64'(st64), 64'(IDLE));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
